// File: rtl/line_mem_responder.sv
// Two-port line-granular backing store with a single shared bus, fixed read latency and write snoop broadcast.
// Define LINE_MEM_RR_ARB_EN for round-robin tie-breaking; otherwise port 0 always wins ties.
module line_mem_responder #(
  parameter int N             = 32,
  parameter int WORDSPERLINE  = 2,
  parameter int LINEADDRWIDTH = 12,
  parameter int RD_LATENCY    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0]                   p0_addr,
  input  logic [WORDSPERLINE-1:0][N-1:0] p0_wdata,
  input  logic                           p0_re,
  input  logic                           p0_we,
  output logic [WORDSPERLINE-1:0][N-1:0] p0_rdata,
  output logic                           p0_ready,
  output logic                           p0_granted,
  input  logic [N-1:0]                   p1_addr,
  input  logic [WORDSPERLINE-1:0][N-1:0] p1_wdata,
  input  logic                           p1_re,
  input  logic                           p1_we,
  output logic [WORDSPERLINE-1:0][N-1:0] p1_rdata,
  output logic                           p1_ready,
  output logic                           p1_granted,
  output logic [N-1:0]                   snoop_addr,
  output logic                           snoop_we
);
  localparam int       OFFS = $clog2(WORDSPERLINE * 4);
  localparam logic [3:0] LAT = 4'(RD_LATENCY);

  typedef logic [WORDSPERLINE-1:0][N-1:0] line_t;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_COMMIT, WR_RESP} state_t;

  line_t mem [2**LINEADDRWIDTH];

  logic [1:0][N-1:0]                   req_addr;
  logic [1:0][WORDSPERLINE-1:0][N-1:0] req_wdata;
  logic [1:0]                          req_re, req_we;
  logic [1:0][WORDSPERLINE-1:0][N-1:0] rdata_q;
  logic [1:0]                          ready_q, gnt_q;

  state_t                   state;
  logic                     owner;
  logic [3:0]               lat_cnt;
  logic [LINEADDRWIDTH-1:0] lat_idx;
  line_t                    lat_data;
  logic                     win;
`ifdef LINE_MEM_RR_ARB_EN
  logic                     rr_ptr;
`endif

  assign req_addr  = {p1_addr, p0_addr};
  assign req_wdata = {p1_wdata, p0_wdata};
  assign req_re    = {p1_re, p0_re};
  assign req_we    = {p1_we, p0_we};

  assign p0_rdata   = rdata_q[0];
  assign p1_rdata   = rdata_q[1];
  assign p0_ready   = ready_q[0];
  assign p1_ready   = ready_q[1];
  assign p0_granted = gnt_q[0];
  assign p1_granted = gnt_q[1];

  // Lone requester wins; a tie goes to the preferred port.
  always_comb begin
    win = req_re[1] & ~req_re[0];
`ifdef LINE_MEM_RR_ARB_EN
    if (&req_re) win = rr_ptr;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      lat_cnt    <= '0;
      ready_q    <= '0;
      gnt_q      <= '0;
      rdata_q    <= '0;
      snoop_we   <= 1'b0;
      snoop_addr <= '0;
`ifdef LINE_MEM_RR_ARB_EN
      rr_ptr     <= 1'b0;
`endif
    end else begin
      snoop_we <= 1'b0;
      case (state)
        IDLE: if (|req_re) begin
          owner      <= win;
          gnt_q[win] <= 1'b1;
          lat_idx    <= req_addr[win][LINEADDRWIDTH-1:0];
          lat_data   <= req_wdata[win];
          lat_cnt    <= '0;
`ifdef LINE_MEM_RR_ARB_EN
          rr_ptr     <= ~win;
`endif
          if (req_we[win]) begin
            snoop_we   <= 1'b1;
            snoop_addr <= req_addr[win] << OFFS;
            state      <= WR_COMMIT;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (!req_re[owner]) begin
            gnt_q <= '0;
            state <= IDLE;
          end else if (lat_cnt == LAT) begin
            rdata_q[owner] <= mem[lat_idx];
            ready_q[owner] <= 1'b1;
            state          <= RD_RESP;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        WR_COMMIT: begin
          rdata_q[owner] <= lat_data;
          ready_q[owner] <= 1'b1;
          state          <= WR_RESP;
        end
        RD_RESP: begin
          if (!req_re[owner]) begin
            ready_q <= '0;
            gnt_q   <= '0;
            state   <= IDLE;
          end else if (req_we[owner]) begin
            // Writeback after a read, without giving up the bus.
            ready_q    <= '0;
            lat_idx    <= req_addr[owner][LINEADDRWIDTH-1:0];
            lat_data   <= req_wdata[owner];
            snoop_we   <= 1'b1;
            snoop_addr <= req_addr[owner] << OFFS;
            state      <= WR_COMMIT;
          end
        end
        WR_RESP: if (!req_re[owner]) begin
          ready_q <= '0;
          gnt_q   <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && state == WR_COMMIT) mem[lat_idx] <= lat_data;
  end
endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: transaction-level reference model, per-cycle compare, directed and random stimulus.
module tb_line_mem_responder;
  localparam int N = 32, WPL = 2, LAW = 12, LAT = 4, OFFS = 3;
  localparam int LW = WPL * N;
`ifdef LINE_MEM_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0, rst;
  logic [N-1:0]  addr [2];
  logic [LW-1:0] wdata [2];
  logic          re [2], we [2];
  logic [WPL-1:0][N-1:0] p0_rdata, p1_rdata;
  logic p0_ready, p0_granted, p1_ready, p1_granted, snoop_we;
  logic [N-1:0] snoop_addr;
  logic [LW-1:0] rdata [2];
  logic rdy [2], gnt [2];

  assign rdata[0] = p0_rdata;
  assign rdata[1] = p1_rdata;
  assign rdy[0] = p0_ready;
  assign rdy[1] = p1_ready;
  assign gnt[0] = p0_granted;
  assign gnt[1] = p1_granted;

  line_mem_responder #(.N(N), .WORDSPERLINE(WPL), .LINEADDRWIDTH(LAW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_re(re[0]), .p0_we(we[0]),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready), .p0_granted(p0_granted),
    .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_re(re[1]), .p1_we(we[1]),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready), .p1_granted(p1_granted),
    .snoop_addr(snoop_addr), .snoop_we(snoop_we)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: who owns the bus, how many edges since the grant, and the store contents.
  logic [LW-1:0] m_mem [int];
  int            m_owner, m_age, m_last, w, o, k;
  bit            m_wr, m_done;
  logic [N-1:0]  m_line;
  logic [LW-1:0] m_data;
  logic          e_rdy [2], e_gnt [2], e_swe;
  logic [LW-1:0] e_rdata [2];
  bit            e_known [2];
  logic [N-1:0]  e_saddr;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_last = 1; e_swe = 1'b0; e_saddr = '0;
      for (int p = 0; p < 2; p++) begin
        e_rdy[p] = 1'b0; e_gnt[p] = 1'b0; e_rdata[p] = '0; e_known[p] = 1'b1;
      end
    end else begin
      e_swe = 1'b0;
      if (m_owner < 0) begin
        if (re[0] || re[1]) begin
          if (re[0] && re[1]) w = RR ? 1 - m_last : 0;
          else w = re[0] ? 0 : 1;
          m_owner = w; m_last = w; e_gnt[w] = 1'b1; m_age = 0; m_done = 1'b0;
          m_line = addr[w]; m_data = wdata[w]; m_wr = we[w];
          if (m_wr) begin e_swe = 1'b1; e_saddr = addr[w] << OFFS; end
        end
      end else begin
        o = m_owner;
        k = int'(m_line[LAW-1:0]);
        if (!m_done && !m_wr) begin
          if (!re[o]) begin
            e_gnt[o] = 1'b0; m_owner = -1;
          end else begin
            m_age++;
            if (m_age == LAT + 1) begin
              e_known[o] = m_mem.exists(k);
              if (e_known[o]) e_rdata[o] = m_mem[k];
              e_rdy[o] = 1'b1; m_done = 1'b1;
            end
          end
        end else if (!m_done) begin
          m_mem[k] = m_data; e_rdata[o] = m_data; e_known[o] = 1'b1;
          e_rdy[o] = 1'b1; m_done = 1'b1;
        end else if (!re[o]) begin
          e_rdy[o] = 1'b0; e_gnt[o] = 1'b0; m_owner = -1;
        end else if (!m_wr && we[o]) begin
          m_wr = 1'b1; m_done = 1'b0; m_line = addr[o]; m_data = wdata[o];
          e_rdy[o] = 1'b0; e_swe = 1'b1; e_saddr = addr[o] << OFFS;
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    for (int p = 0; p < 2; p++) begin
      check($sformatf("p%0d_ready", p), LW'(rdy[p]), LW'(e_rdy[p]));
      check($sformatf("p%0d_granted", p), LW'(gnt[p]), LW'(e_gnt[p]));
      if (e_known[p]) check($sformatf("p%0d_rdata", p), rdata[p], e_rdata[p]);
    end
    check("snoop_we", LW'(snoop_we), LW'(e_swe));
    check("snoop_addr", LW'(snoop_addr), LW'(e_saddr));
    check("one_grant", LW'(gnt[0] & gnt[1]), '0);
  end

  task automatic idle_all();
    re[0] = 0; re[1] = 0; we[0] = 0; we[1] = 0;
  endtask

  task automatic wait_rdy(input int p, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rdy[p] && n < 40);
    check(name, LW'(rdy[p]), LW'(1));
  endtask

  task automatic check_all_zero(input string name);
    check(name, LW'({p0_ready, p0_granted, p1_ready, p1_granted, snoop_we}), '0);
    check({name, "_saddr"}, LW'(snoop_addr), '0);
    check({name, "_rd0"}, rdata[0], '0);
    check({name, "_rd1"}, rdata[1], '0);
  endtask

  task automatic write_line(input int p, input logic [N-1:0] a, input logic [LW-1:0] d,
                            input logic [N-1:0] saddr);
    addr[p] = a; wdata[p] = d; re[p] = 1; we[p] = 1;
    @(negedge clk);
    check("wr_granted", LW'(gnt[p]), LW'(1));
    check("wr_snoop_we", LW'(snoop_we), LW'(1));
    check("wr_snoop_addr", LW'(snoop_addr), LW'(saddr));
    @(negedge clk);
    check("wr_snoop_one_cycle", LW'(snoop_we), LW'(0));
    check("wr_granted_held", LW'(gnt[p]), LW'(1));
    check("wr_ready", LW'(rdy[p]), LW'(1));
    check("wr_rdata", rdata[p], d);
    re[p] = 0; we[p] = 0;
    @(negedge clk);
    check("wr_release", LW'({rdy[p], gnt[p]}), '0);
  endtask

  task automatic read_line(input int p, input logic [N-1:0] a, input logic [LW-1:0] d);
    addr[p] = a; re[p] = 1; we[p] = 0;
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      check("rd_not_ready_yet", LW'(rdy[p]), LW'(0));
    end
    @(negedge clk);
    check("rd_ready_at_5", LW'(rdy[p]), LW'(1));
    check("rd_rdata", rdata[p], d);
    re[p] = 0;
    @(negedge clk);
    check("rd_release", LW'({rdy[p], gnt[p]}), '0);
  endtask

  logic [N-1:0] lines [8] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h55, 32'hFFF, 32'h0, 32'h7A1};
  int hold [2];

  initial begin
    rst = 1; idle_all();
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst = 0; chk_en = 1'b1;

    write_line(0, 32'h10, 64'hAAAA0002_AAAA0001, 32'h80);
    read_line(0, 32'h10, 64'hAAAA0002_AAAA0001);
    write_line(1, 32'h20, 64'h9ABCDEF0_12345678, 32'h100);
    read_line(0, 32'h20, 64'h9ABCDEF0_12345678);

    // Address bits above the store index alias onto the same line.
    write_line(0, 32'h1010, 64'h0BAD_F00D_1111_2222, 32'h8080);
    read_line(1, 32'h10, 64'h0BAD_F00D_1111_2222);
    write_line(0, 32'h10, 64'hAAAA0002_AAAA0001, 32'h80);

    // Simultaneous requests, twice.
    repeat (2) begin
      addr[0] = 32'h10; addr[1] = 32'h20; re[0] = 1; re[1] = 1;
      @(negedge clk);
      check("tie_first_p0", LW'({gnt[1], gnt[0]}), LW'(2'b01));
      wait_rdy(0, "tie_p0_ready");
      re[0] = 0;
      @(negedge clk);
      check("tie_gap", LW'({gnt[1], gnt[0]}), '0);
      @(negedge clk);
      check("tie_second_p1", LW'({gnt[1], gnt[0]}), LW'(2'b10));
      wait_rdy(1, "tie_p1_ready");
      check("tie_p1_rdata", rdata[1], 64'h9ABCDEF0_12345678);
      re[1] = 0;
      @(negedge clk);
    end

    // Read then writeback under one grant.
    write_line(1, 32'h30, 64'h3333_3333_3030_3030, 32'h180);
    addr[0] = 32'h30; re[0] = 1;
    wait_rdy(0, "wb_read_ready");
    check("wb_read_rdata", rdata[0], 64'h3333_3333_3030_3030);
    we[0] = 1; wdata[0] = 64'hCAFE_0001_BEEF_0002;
    @(negedge clk);
    check("wb_ready_drop", LW'(rdy[0]), LW'(0));
    check("wb_snoop", LW'({snoop_we, gnt[0]}), LW'(2'b11));
    check("wb_snoop_addr", LW'(snoop_addr), LW'(32'h180));
    @(negedge clk);
    check("wb_ready_rise", LW'({rdy[0], gnt[0], snoop_we}), LW'(3'b110));
    check("wb_rdata", rdata[0], 64'hCAFE_0001_BEEF_0002);
    re[0] = 0; we[0] = 0;
    @(negedge clk);
    read_line(1, 32'h30, 64'hCAFE_0001_BEEF_0002);

    // Abort during read wait hands the bus to the waiting port.
    addr[0] = 32'h10; re[0] = 1;
    @(negedge clk);
    addr[1] = 32'h20; re[1] = 1;
    @(negedge clk);
    re[0] = 0;
    @(negedge clk);
    check("abort_release", LW'({rdy[0], gnt[0], gnt[1]}), '0);
    @(negedge clk);
    check("abort_p1_granted", LW'(gnt[1]), LW'(1));
    wait_rdy(1, "abort_p1_ready");
    re[1] = 0;
    @(negedge clk);

    // Reset during read wait, then re-issue.
    addr[0] = 32'h20; re[0] = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_all_zero("midreset");
    rst = 0;
    wait_rdy(0, "post_reset_ready");
    check("post_reset_rdata", rdata[0], 64'h9ABCDEF0_12345678);
    re[0] = 0;
    @(negedge clk);

    // Random traffic over a small, fully initialised line set.
    for (int i = 0; i < 8; i++) write_line(i % 2, lines[i], {$urandom, $urandom}, lines[i] << OFFS);
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < 2; p++) begin
        if (hold[p] == 0) begin
          re[p] = ($urandom_range(0, 3) != 0);
          we[p] = ($urandom_range(0, 3) == 0);
          hold[p] = $urandom_range(1, 12);
        end else hold[p]--;
        if ($urandom_range(0, 9) == 0) we[p] = ~we[p];
        addr[p] = ($urandom & 32'hFFFF_F000) | lines[$urandom_range(0, 7)];
        wdata[p] = {$urandom, $urandom};
      end
      @(negedge clk);
    end
    rst = 0; idle_all();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
